fetch_buffer: RTL and testbench

- Fetch stage that sits directly downstream of the IF PC register.
- Takes the current PC, issues in-order instruction-memory read requests, and pairs each returned instruction with its PC in a small in-order buffer.
- Presents {pc, instr} to decode with a valid/ready handshake.
- Back-pressures the PC register when the buffer is full.
- Discards stale instructions on a branch or trap redirect.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_buffer.sv | 116 +++++++++++
 tb/tb_fetch_buffer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            filled;
    } fetch_slot_t;

    // Decode-facing bundle.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } id_fetch_d;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            valid;
    } if_reg_d;

endpackage

// File: rtl/fetch_buffer.sv
// In-order fetch buffer: issues imem reads for incoming PCs, pairs each returned
// word with its PC and hands {pc, instr} to decode; stale responses are dropped after a flush.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_in,
    input  logic             pc_valid,
    output logic             pc_ready,
    input  logic             flush,
    output logic             imem_req_valid,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_req_ready,
    input  logic             imem_resp_valid,
    input  logic [WIDTH-1:0] imem_resp_data,
    output logic             id_valid,
    output logic [WIDTH-1:0] id_pc,
    output logic [WIDTH-1:0] id_instr,
    input  logic             id_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Handshakes: a transfer happens on a channel exactly in the cycle where its
    // valid and ready are both high; valid never depends on the same channel's ready.

    logic [PW-1:0]    alloc_ptr, fill_ptr, read_ptr, drop_cnt;
    logic [WIDTH-1:0] slot_pc    [DEPTH];
    logic [WIDTH-1:0] slot_instr [DEPTH];
    logic [DEPTH-1:0] slot_filled;

    logic [AW-1:0] alloc_idx, fill_idx, read_idx;
    logic [PW-1:0] in_flight;
    logic [PW:0]   used;
    logic          credit_ok, req_fire, dropping, fill_en, pop;

    assign alloc_idx = alloc_ptr[AW-1:0];
    assign fill_idx  = fill_ptr[AW-1:0];
    assign read_idx  = read_ptr[AW-1:0];

    // Requests still owed a response that will land in a slot.
    assign in_flight = alloc_ptr - fill_ptr;
    // Credits use pre-update values, so a same-cycle pop does not free a slot.
    assign used      = {1'b0, alloc_ptr - read_ptr} + {1'b0, drop_cnt};
    assign credit_ok = used < (PW+1)'(DEPTH);

    assign imem_req_valid = pc_valid & ~flush & ~rst & credit_ok;
    assign imem_req_addr  = pc_in;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign pc_ready       = req_fire;

    assign dropping = (drop_cnt != '0);
    assign fill_en  = imem_resp_valid & ~dropping & ~flush;

    assign id_valid = (read_ptr != fill_ptr) & slot_filled[read_idx];
    assign id_pc    = slot_pc[read_idx];
    assign id_instr = slot_instr[read_idx];
    assign pop      = id_valid & id_ready & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            read_ptr    <= '0;
            drop_cnt    <= '0;
            slot_filled <= '0;
        end else if (flush) begin
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            read_ptr    <= '0;
            slot_filled <= '0;
            // Any response this cycle is discarded, whether it was already stale or not.
            drop_cnt    <= drop_cnt + in_flight - PW'(imem_resp_valid);
        end else begin
            if (req_fire) begin
                slot_filled[alloc_idx] <= 1'b0;
                alloc_ptr              <= alloc_ptr + 1'b1;
            end
            if (fill_en) begin
                slot_filled[fill_idx] <= 1'b1;
                fill_ptr              <= fill_ptr + 1'b1;
            end
            if (imem_resp_valid && dropping) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
            if (pop) begin
                read_ptr <= read_ptr + 1'b1;
            end
        end
    end

    // Slot payload needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (req_fire) begin
                slot_pc[alloc_idx] <= pc_in;
            end
            if (fill_en) begin
                slot_instr[fill_idx] <= imem_resp_data;
            end
        end
    end

    logic [PW:0] outstanding;
    assign outstanding = {1'b0, in_flight} + {1'b0, drop_cnt};

    a_resp_has_request: assert property (
        @(posedge clk) disable iff (rst) imem_resp_valid |-> (outstanding != '0)
    );

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomised bench for fetch_buffer: an in-order memory model with tagged
// requests feeds a queue-level reference of what decode should see.
module tb_fetch_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] pc_in;
    logic             pc_valid;
    logic             pc_ready;
    logic             flush;
    logic             imem_req_valid;
    logic [WIDTH-1:0] imem_req_addr;
    logic             imem_req_ready;
    logic             imem_resp_valid;
    logic [WIDTH-1:0] imem_resp_data;
    logic             id_valid;
    logic [WIDTH-1:0] id_pc;
    logic [WIDTH-1:0] id_instr;
    logic             id_ready;

    fetch_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
        .flush(flush), .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .id_valid(id_valid), .id_pc(id_pc),
        .id_instr(id_instr), .id_ready(id_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] pc;
        int               due;
        bit               stale;
    } req_t;

    req_t             pend[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] pc_src[$];
    logic [WIDTH-1:0] out_log[$];
    logic [WIDTH-1:0] issue_log[$];

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int lat_min = 1, lat_max = 1, rdy_pct = 100, idr_pct = 100;

    function automatic logic [WIDTH-1:0] mem_data(input logic [WIDTH-1:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h0000_0013;
    endfunction

    task automatic clear_model();
        pend.delete();
        exp_q.delete();
        pc_src.delete();
        out_log.delete();
        issue_log.delete();
    endtask

    task automatic run_cycle(input bit fl);
        req_t r;
        bit   exp_rv;
        int   used_ref;
        pc_valid       = (pc_src.size() > 0);
        pc_in          = pc_valid ? pc_src[0] : 32'($urandom);
        flush          = fl;
        id_ready       = ($urandom_range(99) < idr_pct);
        imem_req_ready = ($urandom_range(99) < rdy_pct);
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_data(pend[0].pc);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'($urandom);
        end
        #1;
        used_ref = exp_q.size() + pend.size();
        exp_rv   = pc_valid && !fl && (used_ref < DEPTH);
        tests_run++;
        if (imem_req_valid !== exp_rv) begin
            tests_failed++;
            $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_rv);
        end
        tests_run++;
        if (pc_ready !== (exp_rv && imem_req_ready)) begin
            tests_failed++;
            $display("FAIL pc_ready cyc=%0d got=%b exp=%b", cyc, pc_ready, exp_rv && imem_req_ready);
        end
        if (exp_rv) begin
            tests_run++;
            if (imem_req_addr !== pc_src[0]) begin
                tests_failed++;
                $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, pc_src[0]);
            end
        end
        tests_run++;
        if (id_valid !== (exp_q.size() > 0)) begin
            tests_failed++;
            $display("FAIL id_valid cyc=%0d got=%b exp=%b", cyc, id_valid, exp_q.size() > 0);
        end
        if (exp_q.size() > 0) begin
            tests_run++;
            if (id_pc !== exp_q[0] || id_instr !== mem_data(exp_q[0])) begin
                tests_failed++;
                $display("FAIL id_data cyc=%0d got=%h/%h exp=%h/%h", cyc, id_pc, id_instr,
                         exp_q[0], mem_data(exp_q[0]));
            end
        end
        // Observed transfers, for scenario-level ordering checks.
        if (id_valid && id_ready && !fl) out_log.push_back(id_pc);
        if (imem_req_valid && imem_req_ready) issue_log.push_back(imem_req_addr);
        // Reference update.
        if (fl) foreach (pend[i]) pend[i].stale = 1'b1;
        if (imem_resp_valid) r = pend.pop_front();
        if (!fl && exp_q.size() > 0 && id_ready) void'(exp_q.pop_front());
        if (fl) exp_q.delete();
        else if (imem_resp_valid && !r.stale) exp_q.push_back(r.pc);
        if (exp_rv && imem_req_ready) begin
            pend.push_back('{pc_src[0], cyc + $urandom_range(lat_max, lat_min), 1'b0});
            void'(pc_src.pop_front());
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        pc_valid        = 1'b1;
        pc_in           = 32'h0000_0123;
        flush           = 1'b0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        id_ready        = 1'b0;
        clear_model();
        for (int i = 0; i < 2; i++) begin
            #1;
            tests_run++;
            if (imem_req_valid !== 1'b0 || pc_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_gate got=%b/%b exp=0/0", imem_req_valid, pc_ready);
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (id_valid !== 1'b0 || dut.drop_cnt !== '0) begin
            tests_failed++;
            $display("FAIL reset_state got id_valid=%b drop=%0d exp 0/0", id_valid, dut.drop_cnt);
        end
    endtask

    task automatic check_log3(input string name, input logic [WIDTH-1:0] a,
                              input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c);
        tests_run++;
        if (out_log.size() != 3) begin
            tests_failed++;
            $display("FAIL %s_count got=%0d exp=3", name, out_log.size());
        end else begin
            tests_run++;
            if (out_log[0] !== a || out_log[1] !== b || out_log[2] !== c) begin
                tests_failed++;
                $display("FAIL %s_order got=%h,%h,%h exp=%h,%h,%h", name,
                         out_log[0], out_log[1], out_log[2], a, b, c);
            end
        end
    endtask

    task automatic wait_first_out(input string name, input logic [WIDTH-1:0] exp_pc);
        for (int i = 0; i < 60 && out_log.size() == 0; i++) run_cycle(1'b0);
        tests_run++;
        if (out_log.size() == 0) begin
            tests_failed++;
            $display("FAIL %s_timeout got=none exp=%h", name, exp_pc);
        end else if (out_log[0] !== exp_pc) begin
            tests_failed++;
            $display("FAIL %s_first got=%h exp=%h", name, out_log[0], exp_pc);
        end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_stream();
        do_reset();
        lat_min = 1; lat_max = 1; rdy_pct = 100; idr_pct = 100;
        pc_src = '{32'h0, 32'h4, 32'h8};
        for (int i = 0; i < 10; i++) run_cycle(1'b0);
        check_log3("stream", 32'h0, 32'h4, 32'h8);
    endtask

    task automatic test_back_pressure();
        do_reset();
        lat_min = 1; lat_max = 1; rdy_pct = 100; idr_pct = 0;
        pc_src = '{32'h0, 32'h4, 32'h8, 32'hc};
        for (int i = 0; i < 6; i++) run_cycle(1'b0);
        tests_run++;
        if (issue_log.size() != 2) begin
            tests_failed++;
            $display("FAIL bp_issued got=%0d exp=2", issue_log.size());
        end
        idr_pct = 100;
        for (int i = 0; i < 6; i++) run_cycle(1'b0);
        tests_run++;
        if (issue_log.size() < 3 || issue_log[2] !== 32'h8) begin
            tests_failed++;
            $display("FAIL bp_next got=%h exp=%h", (issue_log.size() > 2) ? issue_log[2] : 32'hx, 32'h8);
        end
    endtask

    task automatic test_flush_inflight();
        do_reset();
        lat_min = 8; lat_max = 8; rdy_pct = 100; idr_pct = 100;
        pc_src = '{32'h10, 32'h14};
        run_cycle(1'b0);
        run_cycle(1'b0);
        pc_src = '{32'h200};
        run_cycle(1'b1);
        tests_run++;
        if (dut.drop_cnt !== 2'd2) begin
            tests_failed++;
            $display("FAIL flush_drop got=%0d exp=2", dut.drop_cnt);
        end
        wait_first_out("flush", 32'h200);
    endtask

    task automatic test_flush_with_resp();
        do_reset();
        lat_min = 3; lat_max = 3; rdy_pct = 100; idr_pct = 100;
        pc_src = '{32'h10, 32'h14};
        for (int i = 0; i < 3; i++) run_cycle(1'b0);
        pc_src = '{32'h300};
        run_cycle(1'b1);
        tests_run++;
        if (dut.drop_cnt !== 2'd1) begin
            tests_failed++;
            $display("FAIL flush_resp_drop got=%0d exp=1", dut.drop_cnt);
        end
        wait_first_out("flush_resp", 32'h300);
    endtask

    task automatic test_mid_reset();
        do_reset();
        lat_min = 1; lat_max = 1; rdy_pct = 100; idr_pct = 0;
        pc_src = '{32'h40, 32'h44};
        run_cycle(1'b0);
        lat_min = 5; lat_max = 5;
        run_cycle(1'b0);
        run_cycle(1'b0);
        do_reset();
        lat_min = 1; lat_max = 1; idr_pct = 100;
        pc_src = '{32'h0, 32'h4, 32'h8};
        for (int i = 0; i < 10; i++) run_cycle(1'b0);
        check_log3("mid_reset", 32'h0, 32'h4, 32'h8);
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] base;
        bit fl;
        do_reset();
        lat_min = 1; lat_max = 4; rdy_pct = 70; idr_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            fl = ($urandom_range(99) < 3);
            if (pc_src.size() == 0 || fl) begin
                pc_src.delete();
                base = 32'($urandom) & ~32'h3;
                for (int k = 0; k < 8; k++) pc_src.push_back(base + 32'(4 * k));
            end
            run_cycle(fl);
        end
        pc_src.delete();
        idr_pct = 100;
        for (int i = 0; i < 100 && (pend.size() > 0 || exp_q.size() > 0); i++) run_cycle(1'b0);
        tests_run++;
        if (pend.size() != 0 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL random_drain got=%0d/%0d left exp=0/0", pend.size(), exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        pc_valid = 1'b0; pc_in = '0; flush = 1'b0; imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0; imem_resp_data = '0; id_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_back_pressure();
        test_flush_inflight();
        test_flush_with_resp();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
